fir_mac_sequencer: RTL and testbench

Controller that time-shares one multiply-accumulate unit across all channels and taps of the decimating multi-channel FIR.
- Accepts the input sample stream handshake and generates sample-buffer write addresses.
- Every DECIM accepted beats, launches one compute pass of CHANNELS*TAP_COUNT MAC operations, issuing coefficient address, sample read address, channel select and accumulator control each cycle.
- Sits between the input stream, the circular sample RAM and the MAC/output stage.

---
 rtl/fir_mac_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Shares one multiply-accumulate unit across all channels and taps of a
//   decimating multi-channel FIR. Input beats are written into a circular
//   sample RAM. Every DECIM accepted beats a compute pass of
//   CHANNELS*TAP_COUNT MAC operations is issued, one per cycle.
//   Channel is the outer loop and tap the inner loop.
//
// Ports
//   clk, nrst          clock, asynchronous active-low reset
//   en                 enable: gates s_tready and new pass launches
//   s_tvalid/s_tready  input beat handshake
//   buf_we/buf_waddr   sample RAM write strobe / address
//   mac_en             MAC op valid this cycle
//   mac_clr/mac_last   first / last tap of a channel
//   samp_zero          force sample operand to 0 (history not yet written)
//   samp_raddr         sample RAM read address, (base - k) mod DEPTH
//   coef_addr          coefficient ROM address (tap k)
//   ch_sel             lane select within the sample word
//   out_valid/out_ch   accumulated channel result valid, MAC_LAT after mac_last
//   busy               pass in progress
//
// Optional build macro FIR_SEQ_PERF_EN adds:
//   stall_cnt          cycles with s_tvalid && !s_tready (saturating)
//   pass_cnt           number of pass starts (wrapping)

module fir_mac_sequencer #(
   parameter int unsigned CHANNELS  = 16,
   parameter int unsigned TAP_COUNT = 120,
   parameter int unsigned DECIM     = 8,
   parameter int unsigned DEPTH     = 128,
   parameter int unsigned MAC_LAT   = 3
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         en,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   output logic                         buf_we,
   output logic [$clog2(DEPTH)-1:0]     buf_waddr,
   output logic                         mac_en,
   output logic                         mac_clr,
   output logic                         mac_last,
   output logic                         samp_zero,
   output logic [$clog2(DEPTH)-1:0]     samp_raddr,
   output logic [$clog2(TAP_COUNT)-1:0] coef_addr,
   output logic [$clog2(CHANNELS)-1:0]  ch_sel,
   output logic                         out_valid,
   output logic [$clog2(CHANNELS)-1:0]  out_ch,
`ifdef FIR_SEQ_PERF_EN
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  pass_cnt,
`endif
   output logic                         busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned KW = $clog2(TAP_COUNT);
   localparam int unsigned HW = $clog2(CHANNELS);
   localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned FW = $clog2(TAP_COUNT + 1);
   localparam int unsigned SW = HW + 1;

   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(TAP_COUNT - 1);
   localparam logic [HW-1:0] CH_LAST   = HW'(CHANNELS - 1);
   localparam logic [PW-1:0] PH_LAST   = PW'(DECIM - 1);
   localparam logic [FW-1:0] FILL_MAX  = FW'(TAP_COUNT);

   if (DEPTH < TAP_COUNT + DECIM) begin : g_depth_chk
      $error("fir_mac_sequencer: DEPTH must be >= TAP_COUNT + DECIM");
   end
   if (MAC_LAT < 1) begin : g_lat_chk
      $error("fir_mac_sequencer: MAC_LAT must be >= 1");
   end

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   logic          rdy;          // low only until the first clock after reset
   logic [AW-1:0] wr_ptr;
   logic [PW-1:0] phase;
   logic [FW-1:0] fill;
   logic          pending;
   logic [AW-1:0] pend_base;
   logic [FW-1:0] pend_fill;
   logic [AW-1:0] run_base;
   logic [FW-1:0] run_fill;

   logic          hs;
   logic          trig;
   logic          last_op;
   logic [FW-1:0] fill_inc;
   logic [KW-1:0] k_next;
   logic          start;
   logic [AW-1:0] start_base;
   logic [FW-1:0] start_fill;

   assign s_tready  = en & ~pending & rdy;
   assign hs        = s_tvalid & s_tready;
   assign buf_we    = hs;
   assign buf_waddr = wr_ptr;
   assign trig      = hs & (phase == PH_LAST);
   assign busy      = (state == RUN);
   assign last_op   = (state == RUN) && (ch_sel == CH_LAST) && (coef_addr == K_LAST);
   assign fill_inc  = (fill == FILL_MAX) ? fill : fill + 1'b1;
   assign k_next    = coef_addr + 1'b1;

   // A waiting pass has priority at end of pass; otherwise a trigger landing
   // on the final op starts directly without going through pending.
   always_comb begin
      start      = 1'b0;
      start_base = wr_ptr;
      start_fill = fill_inc;
      if (state == IDLE) begin
         start = trig;
      end else if (last_op) begin
         if (pending) begin
            start      = 1'b1;
            start_base = pend_base;
            start_fill = pend_fill;
         end else begin
            start = trig;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         rdy        <= 1'b0;
         wr_ptr     <= '0;
         phase      <= '0;
         fill       <= '0;
         pending    <= 1'b0;
         pend_base  <= '0;
         pend_fill  <= '0;
         run_base   <= '0;
         run_fill   <= '0;
         mac_en     <= 1'b0;
         mac_clr    <= 1'b0;
         mac_last   <= 1'b0;
         samp_zero  <= 1'b0;
         samp_raddr <= '0;
         coef_addr  <= '0;
         ch_sel     <= '0;
      end else begin
         rdy <= 1'b1;

         if (hs) begin
            wr_ptr <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + 1'b1;
            phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            fill   <= fill_inc;
         end

         if (start) begin
            state      <= RUN;
            run_base   <= start_base;
            run_fill   <= start_fill;
            pending    <= 1'b0;
            mac_en     <= 1'b1;
            mac_clr    <= 1'b1;
            mac_last   <= (K_LAST == '0);
            samp_zero  <= (start_fill == '0);
            samp_raddr <= start_base;
            coef_addr  <= '0;
            ch_sel     <= '0;
         end else if (last_op) begin
            state      <= IDLE;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            mac_last   <= 1'b0;
            samp_zero  <= 1'b0;
            samp_raddr <= '0;
            coef_addr  <= '0;
            ch_sel     <= '0;
         end else if (state == RUN) begin
            if (coef_addr == K_LAST) begin
               coef_addr  <= '0;
               ch_sel     <= ch_sel + 1'b1;
               samp_raddr <= run_base;
               mac_clr    <= 1'b1;
               mac_last   <= (K_LAST == '0);
               samp_zero  <= (run_fill == '0);
            end else begin
               coef_addr  <= k_next;
               ch_sel     <= ch_sel;
               samp_raddr <= (samp_raddr == '0) ? ADDR_LAST : samp_raddr - 1'b1;
               mac_clr    <= 1'b0;
               mac_last   <= (k_next == K_LAST);
               samp_zero  <= (FW'(k_next) >= run_fill);
            end
         end

         // Trigger mid-pass: remember it; s_tready drops from next cycle on.
         if (trig && (state == RUN) && !last_op) begin
            pending   <= 1'b1;
            pend_base <= wr_ptr;
            pend_fill <= fill_inc;
         end
      end
   end

   // mac_last/ch_sel delay line: newest stage in the low bits.
   logic [MAC_LAT*SW-1:0] dly;
   logic [MAC_LAT*SW-1:0] dly_next;

   if (MAC_LAT > 1) begin : g_dly_multi
      assign dly_next = {dly[(MAC_LAT-1)*SW-1:0], mac_last, ch_sel};
   end else begin : g_dly_one
      assign dly_next = {mac_last, ch_sel};
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dly <= '0;
      end else begin
         dly <= dly_next;
      end
   end

   assign out_valid = dly[MAC_LAT*SW-1];
   assign out_ch    = dly[MAC_LAT*SW-2 -: HW];

`ifdef FIR_SEQ_PERF_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cnt <= '0;
         pass_cnt  <= '0;
      end else begin
         if (s_tvalid && !s_tready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (start) begin
            pass_cnt <= pass_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

   localparam int unsigned CHANNELS  = 16;
   localparam int unsigned TAP_COUNT = 120;
   localparam int unsigned DECIM     = 8;
   localparam int unsigned DEPTH     = 128;
   localparam int unsigned MAC_LAT   = 3;
   localparam int          NOPS      = CHANNELS * TAP_COUNT;
   localparam int          D         = DEPTH;

   logic clk = 1'b0;
   logic nrst, en, s_tvalid;
   logic s_tready, buf_we, mac_en, mac_clr, mac_last, samp_zero, out_valid, busy;
   logic [$clog2(DEPTH)-1:0]     buf_waddr, samp_raddr;
   logic [$clog2(TAP_COUNT)-1:0] coef_addr;
   logic [$clog2(CHANNELS)-1:0]  ch_sel, out_ch;
`ifdef FIR_SEQ_PERF_EN
   logic [31:0] stall_cnt, pass_cnt;
`endif

   always #5 clk = ~clk;

   fir_mac_sequencer #(
      .CHANNELS (CHANNELS),
      .TAP_COUNT(TAP_COUNT),
      .DECIM    (DECIM),
      .DEPTH    (DEPTH),
      .MAC_LAT  (MAC_LAT)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .en        (en),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .buf_we    (buf_we),
      .buf_waddr (buf_waddr),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
      .mac_last  (mac_last),
      .samp_zero (samp_zero),
      .samp_raddr(samp_raddr),
      .coef_addr (coef_addr),
      .ch_sel    (ch_sel),
      .out_valid (out_valid),
      .out_ch    (out_ch),
`ifdef FIR_SEQ_PERF_EN
      .stall_cnt (stall_cnt),
      .pass_cnt  (pass_cnt),
`endif
      .busy      (busy)
   );

   typedef struct { int k; int ch; int raddr; bit zero; } op_t;
   typedef struct { int ch; int cyc; } out_t;
   typedef struct { int base; int fill; } req_t;

   op_t  op_q[$];
   out_t out_q[$];
   req_t req_q[$];   // pass requests not yet started (size 1 == pending)

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model state
   int m_wr, m_fill, m_beats, m_op;
   bit m_rdy;
   int unsigned m_stall, m_pass;
   bit hs, exp_rdy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_wr = 0; m_fill = 0; m_beats = 0; m_op = -1; m_rdy = 0;
      m_stall = 0; m_pass = 0;
      op_q.delete(); out_q.delete(); req_q.delete();
   endtask

   // Expand a pass into its full op list and its channel result times.
   task automatic start_pass(input req_t r);
      m_op = 0;
      m_pass++;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         for (int k = 0; k < TAP_COUNT; k++) begin
            op_q.push_back('{k, ch, (r.base - k + D) % D, k >= r.fill});
         end
         out_q.push_back('{ch, cyc + ch * TAP_COUNT + TAP_COUNT - 1 + MAC_LAT});
      end
   endtask

   task automatic model_edge(input bit v);
      if (hs) begin
         m_beats++;
         if (m_fill < TAP_COUNT) m_fill++;
         if (m_beats % DECIM == 0) req_q.push_back('{m_wr, m_fill});
         m_wr = (m_wr + 1) % D;
      end
      if (m_op >= 0 && m_op < NOPS - 1) m_op++;
      else if (req_q.size() > 0) start_pass(req_q.pop_front());
      else m_op = -1;
      if (v && !exp_rdy) m_stall++;
      m_rdy = 1;
   endtask

   // One clock: drive at negedge, check at +1, advance model at posedge.
   task automatic cycle(input bit v, input bit e, input bit r);
      nrst = r; s_tvalid = v; en = e;
      #1;
      if (!r) begin
         model_reset();
         hs = 0; exp_rdy = 0;
         chk("reset_outputs", {s_tready, buf_we, buf_waddr, mac_en, mac_clr, mac_last, samp_zero,
                               samp_raddr, coef_addr, ch_sel, out_valid, out_ch, busy}, 0);
`ifdef FIR_SEQ_PERF_EN
         chk("reset_perf", {stall_cnt, pass_cnt}, 0);
`endif
      end else begin
         exp_rdy = e && m_rdy && (req_q.size() == 0);
         hs = v && exp_rdy;
         chk("s_tready", s_tready, exp_rdy);
         chk("buf_we", buf_we, hs);
         if (hs) chk("buf_waddr", buf_waddr, m_wr);
         chk("mac_en", mac_en, m_op >= 0);
         chk("busy", busy, m_op >= 0);
`ifdef FIR_SEQ_PERF_EN
         chk("stall_cnt", stall_cnt, m_stall);
         chk("pass_cnt", pass_cnt, m_pass);
`endif
      end
      @(posedge clk);
      cyc++;
      if (r) model_edge(v);
      @(negedge clk);
   endtask

   task automatic feed_beats(input int count, input int budget, input string name);
      int target = m_beats + count;
      int n = 0;
      while (m_beats < target && n < budget) begin cycle(1, 1, 1); n++; end
      chk({name, "_timeout"}, m_beats, target);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((m_op >= 0 || out_q.size() > 0) && n < budget) begin cycle(0, 1, 1); n++; end
      chk({name, "_timeout"}, (m_op >= 0 || out_q.size() > 0), 0);
   endtask

   task automatic run_to_op(input int target, input int budget, input string name);
      int n = 0;
      while (m_op != target && n < budget) begin cycle(0, 1, 1); n++; end
      chk({name, "_timeout"}, m_op, target);
   endtask

   // Monitor: compare every presented op and result against the scoreboard.
   initial begin : monitor
      op_t  o;
      out_t w;
      forever begin
         @(negedge clk);
         #2;
         if (nrst === 1'b1) begin
            if (mac_en === 1'b1) begin
               if (op_q.size() == 0) begin
                  chk("spurious_mac_en", mac_en, 0);
               end else begin
                  o = op_q.pop_front();
                  chk("coef_addr", coef_addr, o.k);
                  chk("samp_raddr", samp_raddr, o.raddr);
                  chk("ch_sel", ch_sel, o.ch);
                  chk("mac_clr", mac_clr, o.k == 0);
                  chk("mac_last", mac_last, o.k == TAP_COUNT - 1);
                  chk("samp_zero", samp_zero, o.zero);
               end
            end
            if (out_valid === 1'b1) begin
               if (out_q.size() == 0) begin
                  chk("spurious_out_valid", out_valid, 0);
               end else begin
                  w = out_q.pop_front();
                  chk("out_ch", out_ch, w.ch);
                  chk("out_valid_cycle", cyc, w.cyc);
               end
            end
            while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
               w = out_q.pop_front();
               chk("out_valid_missing", 0, 1);
            end
         end
      end
   end

   initial begin : main
      int n;
      nrst = 1'b0; en = 1'b0; s_tvalid = 1'b0;
      @(negedge clk);
      repeat (3) cycle(0, 0, 0);

      // single pass from 8 contiguous beats
      feed_beats(8, 100, "a_feed");
      wait_idle(2500, "a_drain");

      // continuous input: pending pass and back-to-back passes
      feed_beats(24, 6000, "b_feed");
      wait_idle(6000, "b_drain");

      // en dropped mid-pass
      feed_beats(8, 100, "c_feed");
      run_to_op(100, 200, "c_op100");
      repeat (2100) cycle(1, 0, 1);
      feed_beats(8, 100, "c_refeed");
      wait_idle(2500, "c_drain");

      // reset mid-pass
      feed_beats(8, 100, "d_feed");
      run_to_op(500, 700, "d_op500");
      repeat (2) cycle(0, 1, 0);

      // random traffic from reset through pointer wrap (17 passes)
      n = 0;
      while (m_beats < 17 * DECIM && n < 60000) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, 1);
         n++;
      end
      chk("e_random_timeout", m_beats, 17 * DECIM);
      wait_idle(8000, "e_drain");

      // trigger beat on the final op with nothing pending
      feed_beats(8, 100, "f_feed");
      feed_beats(DECIM - 1, 100, "f_feed7");
      run_to_op(NOPS - 1, 2500, "f_lastop");
      cycle(1, 1, 1);
      wait_idle(2500, "f_drain");

      chk("op_q_drained", op_q.size(), 0);
      chk("out_q_drained", out_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
